// File: rtl/controlador_partida.sv
// Game sequencer for the 8x8 naval battle: drives piece placement for both
// players, arbitrates turn-based shots against the board memory, keeps score.
module controlador_partida #(
    parameter int N_SUB       = 5,
    parameter int N_CRU       = 2,
    parameter int N_HID       = 2,
    parameter int N_ENC       = 1,
    parameter int N_PA        = 1,
    parameter int TOTAL_CELLS = N_SUB + 2*N_CRU + 3*N_HID + 4*N_ENC + 5*N_PA
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       mode,
    input  logic       place_done,
    output logic       place_enable,
    output logic [2:0] place_tipo,
    output logic       jogador,
    output logic       cpu_turn,
    input  logic       attack_valid,
    input  logic [2:0] attack_x,
    input  logic [2:0] attack_y,
    output logic       mem_req,
    output logic       mem_jogador,
    output logic [2:0] mem_x,
    output logic [2:0] mem_y,
    input  logic       mem_ack,
    input  logic       mem_ocupado,
    input  logic       mem_atingido,
    output logic       mem_mark,
    output logic [1:0] resultado,
    output logic       resultado_valid,
    output logic [4:0] placar0,
    output logic [4:0] placar1,
    output logic [1:0] fase,
    output logic       vencedor,
    output logic       fim
);

    localparam int N_PIECES = N_SUB + N_CRU + N_HID + N_ENC + N_PA;

    // Piece index boundaries where the requested type steps up
    localparam logic [3:0] B_CRU = 4'(N_SUB);
    localparam logic [3:0] B_HID = 4'(N_SUB + N_CRU);
    localparam logic [3:0] B_ENC = 4'(N_SUB + N_CRU + N_HID);
    localparam logic [3:0] B_PA  = 4'(N_SUB + N_CRU + N_HID + N_ENC);
    localparam logic [3:0] LAST  = 4'(N_PIECES - 1);
    localparam logic [4:0] TOTAL = 5'(TOTAL_CELLS);

    typedef enum logic [2:0] {
        S_IDLE, S_PLACE, S_ATTACK, S_LOOKUP, S_RESULT, S_END
    } state_t;

    state_t     state, state_n;
    logic [3:0] idx;
    logic       mode_r;
    logic       ocupado_r, atingido_r;
    logic       hit;
    logic [4:0] score_cur, score_inc;

    assign hit       = ocupado_r & ~atingido_r;
    assign score_cur = jogador ? placar1 : placar0;
    assign score_inc = (score_cur == TOTAL) ? TOTAL : score_cur + 5'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      state <= S_IDLE;
        else if (enable) state <= state_n;
    end

    always_comb begin
        state_n         = state;
        fase            = 2'b00;
        place_enable    = 1'b0;
        place_tipo      = 3'd0;
        mem_req         = 1'b0;
        mem_jogador     = 1'b0;
        resultado_valid = 1'b0;
        mem_mark        = 1'b0;
        cpu_turn        = 1'b0;
        fim             = 1'b0;
        case (state)
            S_IDLE: state_n = S_PLACE;
            S_PLACE: begin
                fase         = 2'b01;
                place_enable = 1'b1;
                cpu_turn     = mode_r & jogador;
                if      (idx < B_CRU) place_tipo = 3'd1;
                else if (idx < B_HID) place_tipo = 3'd2;
                else if (idx < B_ENC) place_tipo = 3'd3;
                else if (idx < B_PA)  place_tipo = 3'd4;
                else                  place_tipo = 3'd5;
                if (place_done && idx == LAST && jogador) state_n = S_ATTACK;
            end
            S_ATTACK: begin
                fase     = 2'b10;
                cpu_turn = mode_r & jogador;
                if (attack_valid) state_n = S_LOOKUP;
            end
            S_LOOKUP: begin
                fase        = 2'b10;
                cpu_turn    = mode_r & jogador;
                mem_req     = 1'b1;
                mem_jogador = ~jogador;
                if (mem_ack) state_n = S_RESULT;
            end
            S_RESULT: begin
                fase            = 2'b10;
                cpu_turn        = mode_r & jogador;
                // Pulses vanish while paused; the state itself just holds
                resultado_valid = enable;
                mem_mark        = enable & hit;
                state_n         = (hit && score_inc == TOTAL) ? S_END : S_ATTACK;
            end
            S_END: begin
                fase = 2'b11;
                fim  = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= '0;
            mode_r     <= 1'b0;
            jogador    <= 1'b0;
            mem_x      <= '0;
            mem_y      <= '0;
            ocupado_r  <= 1'b0;
            atingido_r <= 1'b0;
            resultado  <= 2'b00;
            placar0    <= '0;
            placar1    <= '0;
            vencedor   <= 1'b0;
        end else if (enable) begin
            case (state)
                S_IDLE: begin
                    mode_r  <= mode;
                    jogador <= 1'b0;
                    idx     <= '0;
                end
                S_PLACE: if (place_done) begin
                    if (idx == LAST) begin
                        idx     <= '0;
                        jogador <= ~jogador;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                S_ATTACK: if (attack_valid) begin
                    mem_x <= attack_x;
                    mem_y <= attack_y;
                end
                S_LOOKUP: if (mem_ack) begin
                    ocupado_r  <= mem_ocupado;
                    atingido_r <= mem_atingido;
                    resultado  <= !mem_ocupado ? 2'b01 : (mem_atingido ? 2'b11 : 2'b10);
                end
                S_RESULT: begin
                    if (!ocupado_r) begin
                        jogador <= ~jogador;
                    end else if (hit) begin
                        if (jogador) placar1 <= score_inc;
                        else         placar0 <= score_inc;
                        if (score_inc == TOTAL) vencedor <= jogador;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_partida.sv
// Directed bench for controlador_partida: placement order, shot outcomes,
// scoring to victory, pause during lookup and asynchronous reset.
module tb_controlador_partida;

    logic       clk = 1'b0;
    logic       reset, enable, mode, place_done;
    logic       place_enable, jogador, cpu_turn;
    logic [2:0] place_tipo;
    logic       attack_valid;
    logic [2:0] attack_x, attack_y;
    logic       mem_req, mem_jogador, mem_ack, mem_ocupado, mem_atingido, mem_mark;
    logic [2:0] mem_x, mem_y;
    logic [1:0] resultado, fase;
    logic       resultado_valid, vencedor, fim;
    logic [4:0] placar0, placar1;

    int tests = 0;
    int fails = 0;
    int exp_tipo [11] = '{1, 1, 1, 1, 1, 2, 2, 3, 3, 4, 5};

    controlador_partida dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .place_done(place_done), .place_enable(place_enable), .place_tipo(place_tipo),
        .jogador(jogador), .cpu_turn(cpu_turn),
        .attack_valid(attack_valid), .attack_x(attack_x), .attack_y(attack_y),
        .mem_req(mem_req), .mem_jogador(mem_jogador), .mem_x(mem_x), .mem_y(mem_y),
        .mem_ack(mem_ack), .mem_ocupado(mem_ocupado), .mem_atingido(mem_atingido),
        .mem_mark(mem_mark), .resultado(resultado), .resultado_valid(resultado_valid),
        .placar0(placar0), .placar1(placar1), .fase(fase),
        .vencedor(vencedor), .fim(fim)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic place_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            place_done = 1'b1;
            tick();
            place_done = 1'b0;
            repeat (4) tick();
        end
    endtask

    // Full shot: request, lookup with ack after wait_cyc cycles, result cycle
    task automatic shot(input logic [2:0] x, input logic [2:0] y, input int wait_cyc,
                        input logic oc, input logic at, input logic [1:0] exp_res,
                        input logic exp_mark, input logic exp_mj);
        attack_valid = 1'b1; attack_x = x; attack_y = y;
        tick();
        attack_valid = 1'b0;
        chk("shot_mem_req", mem_req, 1);
        chk("shot_mem_jogador", mem_jogador, exp_mj);
        chk("shot_mem_x", mem_x, x);
        chk("shot_mem_y", mem_y, y);
        repeat (wait_cyc - 1) tick();
        mem_ack = 1'b1; mem_ocupado = oc; mem_atingido = at;
        tick();
        mem_ack = 1'b0; mem_ocupado = 1'b0; mem_atingido = 1'b0;
        chk("res_valid", resultado_valid, 1);
        chk("resultado", resultado, exp_res);
        chk("mem_mark", mem_mark, exp_mark);
        chk("req_dropped", mem_req, 0);
        tick();
        chk("res_pulse_end", resultado_valid, 0);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; mode = 1'b1; place_done = 1'b0;
        attack_valid = 1'b0; attack_x = '0; attack_y = '0;
        mem_ack = 1'b0; mem_ocupado = 1'b0; mem_atingido = 1'b0;
        repeat (2) tick();
        chk("rst_fase", fase, 0);
        chk("rst_tipo", place_tipo, 0);
        chk("rst_placar0", placar0, 0);
        chk("rst_fim", fim, 0);
        chk("rst_mem_jogador", mem_jogador, 0);
        chk("rst_resultado", resultado, 0);

        reset = 1'b1;
        tick();
        chk("idle_hold", fase, 0);
        enable = 1'b1;
        tick();
        mode = 1'b0;  // must not matter: latched in IDLE
        chk("place_fase", fase, 1);
        chk("place_en", place_enable, 1);
        chk("place_jog0", jogador, 0);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("tipo_%0d", i), place_tipo, exp_tipo[i]);
            place_pulses(1);
        end
        chk("p1_jogador", jogador, 1);
        chk("p1_tipo", place_tipo, 1);
        chk("p1_cpu_turn", cpu_turn, 1);
        place_pulses(11);
        chk("atk_fase", fase, 2);
        chk("atk_jogador", jogador, 0);
        chk("atk_place_en", place_enable, 0);
        chk("atk_tipo", place_tipo, 0);
        place_pulses(1);
        chk("stray_place_done", fase, 2);

        shot(3'd3, 3'd4, 2, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
        chk("water_jogador", jogador, 1);
        chk("water_cpu", cpu_turn, 1);
        chk("water_p0", placar0, 0);
        chk("water_p1", placar1, 0);
        shot(3'd2, 3'd5, 1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
        chk("hit_p1", placar1, 1);
        chk("hit_jogador", jogador, 1);
        chk("hold_resultado", resultado, 2'b10);
        shot(3'd2, 3'd5, 3, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        chk("rep_p1", placar1, 1);
        chk("rep_jogador", jogador, 1);
        shot(3'd7, 3'd7, 1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        chk("back_to_p0", jogador, 0);

        // Pause during lookup: the ack is ignored, lookup resumes afterwards
        attack_valid = 1'b1; attack_x = 3'd0; attack_y = 3'd0;
        tick();
        attack_valid = 1'b0;
        enable = 1'b0; mem_ack = 1'b1; mem_ocupado = 1'b1;
        tick();
        chk("pause_no_result", resultado_valid, 0);
        chk("pause_no_mark", mem_mark, 0);
        chk("pause_req_held", mem_req, 1);
        tick();
        chk("pause_req_held2", mem_req, 1);
        mem_ack = 1'b0; mem_ocupado = 1'b0; enable = 1'b1;
        tick();
        chk("resume_lookup", mem_req, 1);
        chk("resume_placar0", placar0, 0);
        mem_ack = 1'b1; mem_ocupado = 1'b1;
        tick();
        mem_ack = 1'b0; mem_ocupado = 1'b0;
        chk("resume_result", resultado, 2'b10);
        chk("resume_mark", mem_mark, 1);
        tick();
        chk("resume_p0", placar0, 1);

        for (int i = 1; i < 23; i++)
            shot(3'(i % 8), 3'(i / 8), 1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
        chk("p0_23", placar0, 23);
        chk("not_yet_fim", fim, 0);
        shot(3'd7, 3'd2, 1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
        chk("win_placar0", placar0, 24);
        chk("win_fim", fim, 1);
        chk("win_vencedor", vencedor, 0);
        chk("win_fase", fase, 3);
        chk("win_p1", placar1, 1);
        attack_valid = 1'b1;
        tick();
        attack_valid = 1'b0;
        tick();
        chk("end_no_req", mem_req, 0);
        chk("end_fase", fase, 3);

        // Asynchronous reset while a lookup is outstanding
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        tick();
        place_pulses(22);
        chk("g2_attack", fase, 2);
        attack_valid = 1'b1; attack_x = 3'd5; attack_y = 3'd6;
        tick();
        attack_valid = 1'b0;
        chk("g2_req", mem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_fase", fase, 0);
        chk("arst_mem_x", mem_x, 0);
        chk("arst_placar0", placar0, 0);
        chk("arst_fim", fim, 0);
        chk("arst_mem_jogador", mem_jogador, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
